// File: rtl/change_dispenser_pkg.sv
// Shared constants and FSM encoding for the change dispenser.
// Coin values are listed smallest to largest; the one-hot select uses the same order.
package change_dispenser_pkg;

  localparam int kTotalBits = 31;
  localparam int kNumCoins  = 3;
  localparam int kCoin0Val  = 100;
  localparam int kCoin1Val  = 500;
  localparam int kCoin2Val  = 1000;
  localparam int kWaitTime  = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: the largest coin whose value fits in the given amount.
// Outputs all-zero (any=0) when the amount is below the smallest coin.
module change_dispenser_coin_select
  import change_dispenser_pkg::*;
#(
  parameter int TOTAL_BITS = kTotalBits,
  parameter int COIN0_VAL  = kCoin0Val,
  parameter int COIN1_VAL  = kCoin1Val,
  parameter int COIN2_VAL  = kCoin2Val
) (
  input  logic [TOTAL_BITS-1:0] remaining,
  output logic [2:0]            sel,
  output logic [TOTAL_BITS-1:0] value,
  output logic                  any
);

  localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VAL);
  localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VAL);
  localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VAL);

  always_comb begin
    sel   = 3'b000;
    value = '0;
    any   = 1'b0;
    if (remaining >= C2) begin
      sel   = 3'b100;
      value = C2;
      any   = 1'b1;
    end else if (remaining >= C1) begin
      sel   = 3'b010;
      value = C1;
      any   = 1'b1;
    end else if (remaining >= C0) begin
      sel   = 3'b001;
      value = C0;
      any   = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change-return controller: on request or inactivity timeout, pays out the latched
// total greedily, one coin per valid/ready handshake, and reports each coin for deduction.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int TOTAL_BITS  = kTotalBits,
  parameter int WAIT_CYCLES = kWaitTime,
  parameter int COIN0_VAL   = kCoin0Val,
  parameter int COIN1_VAL   = kCoin1Val,
  parameter int COIN2_VAL   = kCoin2Val
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TOTAL_BITS-1:0] current_total,
  input  logic                  i_activity,
  input  logic                  i_return_req,
  output logic                  o_coin_valid,
  input  logic                  i_coin_ready,
  output logic [2:0]            o_coin_sel,
  output logic                  o_sub_valid,
  output logic [TOTAL_BITS-1:0] o_sub_amount,
  output logic                  o_busy,
  output logic                  o_done,
  output state_t                dbg_state
);

  // Handshake: a coin transfers on any posedge where o_coin_valid && i_coin_ready;
  // while valid is high and ready is low, o_coin_sel and remaining stay unchanged.

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [TOTAL_BITS-1:0] C0        = TOTAL_BITS'(COIN0_VAL);

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [TOTAL_BITS-1:0] remaining;
  logic [TOTAL_BITS-1:0] offer_value;

  logic [TOTAL_BITS-1:0] rem_after;
  logic [TOTAL_BITS-1:0] pick_src;
  logic [2:0]            pick_sel;
  logic [TOTAL_BITS-1:0] pick_value;
  logic                  pick_any;
  logic                  total_zero;
  logic                  manual_go;
  logic                  auto_go;

  assign rem_after  = remaining - offer_value;
  // While a coin is on offer, look ahead to the coin that follows its acceptance.
  assign pick_src   = o_coin_valid ? rem_after : remaining;
  assign total_zero = (current_total == '0);
  assign manual_go  = i_return_req && (current_total >= C0);
  assign auto_go    = (wait_cnt == WAIT_LAST) && !total_zero && !i_activity;
  assign dbg_state  = state;

  change_dispenser_coin_select #(
    .TOTAL_BITS (TOTAL_BITS),
    .COIN0_VAL  (COIN0_VAL),
    .COIN1_VAL  (COIN1_VAL),
    .COIN2_VAL  (COIN2_VAL)
  ) u_coin_select (
    .remaining (pick_src),
    .sel       (pick_sel),
    .value     (pick_value),
    .any       (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      remaining    <= '0;
      offer_value  <= '0;
      o_coin_valid <= 1'b0;
      o_coin_sel   <= 3'b000;
      o_sub_valid  <= 1'b0;
      o_sub_amount <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_sub_valid  <= 1'b0;
      o_sub_amount <= '0;
      o_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (total_zero || i_activity) wait_cnt <= '0;
          else if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + CNT_W'(1);
          if (manual_go || auto_go) begin
            state  <= LOAD;
            o_busy <= 1'b1;
          end else if (i_return_req) begin
            state  <= DONE;
            o_busy <= 1'b1;
            o_done <= 1'b1;
          end
        end
        LOAD: begin
          remaining <= current_total;
          state     <= DISPENSE;
        end
        DISPENSE: begin
          if (!o_coin_valid) begin
            if (pick_any) begin
              o_coin_valid <= 1'b1;
              o_coin_sel   <= pick_sel;
              offer_value  <= pick_value;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end else if (i_coin_ready) begin
            remaining    <= rem_after;
            o_sub_valid  <= 1'b1;
            o_sub_amount <= offer_value;
            o_coin_sel   <= pick_sel;
            offer_value  <= pick_value;
            if (!pick_any) begin
              o_coin_valid <= 1'b0;
              state        <= DONE;
              o_done       <= 1'b1;
            end
          end
        end
        DONE: begin
          wait_cnt <= '0;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout, back-pressure, timeout,
// small-total return and mid-sequence reset, with a coin/amount scoreboard.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int W = 31;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] current_total;
  logic         i_activity;
  logic         i_return_req;
  logic         o_coin_valid;
  logic         i_coin_ready;
  logic [2:0]   o_coin_sel;
  logic         o_sub_valid;
  logic [W-1:0] o_sub_amount;
  logic         o_busy;
  logic         o_done;
  state_t       dbg_state;

  logic [2:0]   sel_q[$];
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .current_total (current_total),
    .i_activity    (i_activity),
    .i_return_req  (i_return_req),
    .o_coin_valid  (o_coin_valid),
    .i_coin_ready  (i_coin_ready),
    .o_coin_sel    (o_coin_sel),
    .o_sub_valid   (o_sub_valid),
    .o_sub_amount  (o_sub_amount),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Greedy reference payout with coins 1000/500/100.
  task automatic push_greedy(input int total);
    int t;
    t = total;
    while (t >= 100) begin
      if (t >= 1000) begin
        sel_q.push_back(3'b100); exp_q.push_back(W'(1000)); t -= 1000;
      end else if (t >= 500) begin
        sel_q.push_back(3'b010); exp_q.push_back(W'(500)); t -= 500;
      end else begin
        sel_q.push_back(3'b001); exp_q.push_back(W'(100)); t -= 100;
      end
    end
  endtask

  // One clock: score any coin handed over at this edge, then score the sub pulse after it.
  task automatic tick();
    logic [2:0]   es;
    logic [W-1:0] ea;
    if (o_coin_valid && i_coin_ready && !reset) begin
      es = (sel_q.size() > 0) ? sel_q.pop_front() : 3'b000;
      check("coin_sel", 32'(o_coin_sel), 32'(es));
    end
    @(posedge clk);
    #1;
    if (o_sub_valid) begin
      ea = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("sub_amount", 32'(o_sub_amount), 32'(ea));
    end
  endtask

  task automatic run_until_done(input string tag, input int budget, output int n);
    n = 0;
    while (!o_done && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(o_done), 32'd1);
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_sel_left"}, 32'(sel_q.size()), 32'd0);
    check({tag, "_amt_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; current_total = '0; i_activity = 1'b0;
    i_return_req = 1'b0; i_coin_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(o_coin_valid), 32'd0);
    check("rst_sel",   32'(o_coin_sel),   32'd0);
    check("rst_sub",   32'(o_sub_valid),  32'd0);
    check("rst_amt",   32'(o_sub_amount), 32'd0);
    check("rst_busy",  32'(o_busy),       32'd0);
    check("rst_done",  32'(o_done),       32'd0);
    check("rst_state", 32'(dbg_state),    32'(IDLE));
    reset = 1'b0;
    tick();

    // 1: 1700 under full ready -> 1000,500,100,100 back to back
    current_total = W'(1700); i_return_req = 1'b1; i_coin_ready = 1'b1;
    push_greedy(1700);
    tick(); i_return_req = 1'b0;
    check("t1_busy_load", 32'(o_busy), 32'd1);
    check("t1_valid_load", 32'(o_coin_valid), 32'd0);
    tick();
    check("t1_valid_n1", 32'(o_coin_valid), 32'd0);
    tick();
    check("t1_valid_n2", 32'(o_coin_valid), 32'd1);
    check("t1_first_sel", 32'(o_coin_sel), 32'b100);
    run_until_done("t1_done", 20, cyc);
    current_total = '0;
    check("t1_coin_cycles", 32'(cyc), 32'd4);
    check("t1_busy_at_done", 32'(o_busy), 32'd1);
    tick();
    check("t1_done_pulse", 32'(o_done), 32'd0);
    check("t1_busy_end", 32'(o_busy), 32'd0);
    check_queues("t1");

    // 2: 600 with 3 stalled cycles
    current_total = W'(600); i_return_req = 1'b1; i_coin_ready = 1'b0;
    push_greedy(600);
    tick(); i_return_req = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check("t2_stall_valid", 32'(o_coin_valid), 32'd1);
      check("t2_stall_sel", 32'(o_coin_sel), 32'b010);
      tick();
      check("t2_stall_sub", 32'(o_sub_valid), 32'd0);
    end
    i_coin_ready = 1'b1;
    run_until_done("t2_done", 20, cyc);
    current_total = '0;
    check("t2_coin_cycles", 32'(cyc), 32'd2);
    tick();
    check_queues("t2");

    // 3a: 500 left idle -> automatic return after the wait period
    current_total = W'(500);
    push_greedy(500);
    cyc = 0;
    while (!o_busy && cyc < 50) begin tick(); cyc++; end
    check("t3_auto_cycles", 32'(cyc), 32'd10);
    run_until_done("t3_done", 20, cyc);
    current_total = '0;
    check("t3_coin_cycles", 32'(cyc), 32'd3);
    tick();
    check_queues("t3");

    // 3b: activity partway through restarts the wait
    current_total = W'(500);
    push_greedy(500);
    for (int i = 0; i < 5; i++) tick();
    i_activity = 1'b1;
    tick();
    i_activity = 1'b0;
    check("t3b_busy_after_act", 32'(o_busy), 32'd0);
    cyc = 0;
    while (!o_busy && cyc < 50) begin tick(); cyc++; end
    check("t3b_auto_cycles", 32'(cyc), 32'd10);
    run_until_done("t3b_done", 20, cyc);
    current_total = '0;
    tick();
    check_queues("t3b");

    // 4: return with nothing payable
    for (int k = 0; k < 2; k++) begin
      current_total = (k == 0) ? W'(0) : W'(50);
      i_return_req = 1'b1;
      tick(); i_return_req = 1'b0;
      check("t4_done", 32'(o_done), 32'd1);
      check("t4_busy", 32'(o_busy), 32'd1);
      check("t4_valid", 32'(o_coin_valid), 32'd0);
      tick();
      check("t4_done_end", 32'(o_done), 32'd0);
      check("t4_busy_end", 32'(o_busy), 32'd0);
      check("t4_valid_end", 32'(o_coin_valid), 32'd0);
      check("t4_sub", 32'(o_sub_valid), 32'd0);
    end
    current_total = '0;
    tick();

    // 5: reset while the second coin is on offer
    current_total = W'(1700); i_return_req = 1'b1; i_coin_ready = 1'b1;
    push_greedy(1700);
    tick(); i_return_req = 1'b0;
    tick(); tick(); tick();
    check("t5_second_sel", 32'(o_coin_sel), 32'b010);
    reset = 1'b1;
    tick();
    check("t5_rst_valid", 32'(o_coin_valid), 32'd0);
    check("t5_rst_sub",   32'(o_sub_valid),  32'd0);
    check("t5_rst_done",  32'(o_done),       32'd0);
    check("t5_rst_busy",  32'(o_busy),       32'd0);
    check("t5_rst_sel",   32'(o_coin_sel),   32'd0);
    check("t5_rst_state", 32'(dbg_state),    32'(IDLE));
    reset = 1'b0;
    sel_q.delete(); exp_q.delete();
    current_total = W'(600); i_return_req = 1'b1;
    push_greedy(600);
    tick(); i_return_req = 1'b0;
    run_until_done("t5_restart_done", 20, cyc);
    current_total = '0;
    check("t5_restart_cycles", 32'(cyc), 32'd4);
    tick();
    check_queues("t5");

    // 6: 150 -> a single 100 coin; return request held through dispensing
    current_total = W'(150); i_return_req = 1'b1; i_coin_ready = 1'b0;
    push_greedy(150);
    tick(); tick(); tick();
    check("t6_sel", 32'(o_coin_sel), 32'b001);
    tick();
    check("t6_hold_sel", 32'(o_coin_sel), 32'b001);
    i_coin_ready = 1'b1;
    run_until_done("t6_done", 20, cyc);
    i_return_req = 1'b0; current_total = W'(50);
    check("t6_coin_cycles", 32'(cyc), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle_busy", 32'(o_busy), 32'd0);
      check("t6_idle_valid", 32'(o_coin_valid), 32'd0);
    end
    current_total = '0;
    tick();
    check_queues("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
